// File: rtl/ifu_pkg.sv
// Shared widths and the fill-state encoding for the instruction-fetch unit.
package ifu_pkg;
  localparam int ADDR_WIDTH     = 32;
  localparam int LINE_WIDTH     = 128;
  localparam int MEM_WORD_WIDTH = 32;
  localparam int OFFSET_WIDTH   = 4;
  localparam int TAG_WIDTH      = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int BEATS_PER_LINE = LINE_WIDTH / MEM_WORD_WIDTH;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    RESP      = 2'd3
  } t_fill_state;
endpackage

// File: rtl/ifu_fill_unit.sv
// I-cache line fill: takes a missing tag, issues one memory read, assembles
// BEATS words into a line and returns it, with a one-deep pending buffer.
module ifu_fill_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_WIDTH     = ifu_pkg::ADDR_WIDTH,
  parameter int LINE_WIDTH     = ifu_pkg::LINE_WIDTH,
  parameter int MEM_WORD_WIDTH = ifu_pkg::MEM_WORD_WIDTH,
  parameter int OFFSET_WIDTH   = ifu_pkg::OFFSET_WIDTH
) (
  input  logic                               Clock,
  input  logic                               Rst,
  input  logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] cache_reqTagIn,
  input  logic                               cache_reqTagValidIn,
  output logic                               cache_reqReadyOut,
  output logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] cache_rspTagOut,
  output logic [LINE_WIDTH-1:0]              cache_rspInsLineOut,
  output logic                               cache_rspInsLineValidOut,
  output logic [ADDR_WIDTH-1:0]              mem_reqAddrOut,
  output logic                               mem_reqValidOut,
  input  logic                               mem_reqReadyIn,
  input  logic [MEM_WORD_WIDTH-1:0]          mem_rspDataIn,
  input  logic                               mem_rspValidIn,
  output logic                               busyOut,
  output logic                               errStickyOut
);
  localparam int TAG_W = ADDR_WIDTH - OFFSET_WIDTH;
  localparam int BEATS = LINE_WIDTH / MEM_WORD_WIDTH;

  t_fill_state           state_q, state_d;
  logic [TAG_W-1:0]      tag_q;
  logic [TAG_W-1:0]      pend_tag_q;
  logic                  pend_vld_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [1:0]            cnt_q;
  logic                  err_q;

  logic accept, merge, push, pop, last_beat;

  assign accept    = cache_reqTagValidIn & cache_reqReadyOut;
  // Duplicate of a line already being fetched or queued: accept and drop.
  assign merge     = (state_q != IDLE) &&
                     ((cache_reqTagIn == tag_q) ||
                      (pend_vld_q && (cache_reqTagIn == pend_tag_q)));
  assign push      = accept && (state_q != IDLE) && !merge;
  assign pop       = pend_vld_q && ((state_q == IDLE) || (state_q == RESP));
  assign last_beat = (cnt_q == 2'(BEATS - 1));

  // State register
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pend_vld_q || accept)          state_d = REQ;
      REQ:       if (mem_reqReadyIn)                state_d = WAIT_DATA;
      WAIT_DATA: if (mem_rspValidIn && last_beat)   state_d = RESP;
      RESP:      state_d = pend_vld_q ? REQ : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_reqValidOut          = (state_q == REQ);
    cache_rspInsLineValidOut = (state_q == RESP);
    busyOut                  = (state_q != IDLE);
  end

  assign cache_reqReadyOut   = !pend_vld_q;
  assign cache_rspTagOut     = tag_q;
  assign cache_rspInsLineOut = line_q;
  assign mem_reqAddrOut      = {tag_q, {OFFSET_WIDTH{1'b0}}};
  assign errStickyOut        = err_q;

  // Datapath: in-flight tag, beat assembly, error flag
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      tag_q  <= '0;
      line_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (mem_rspValidIn && (state_q != WAIT_DATA)) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pend_vld_q)  tag_q <= pend_tag_q;
          else if (accept) tag_q <= cache_reqTagIn;
        end
        REQ: if (mem_reqReadyIn) cnt_q <= '0;
        WAIT_DATA: begin
          if (mem_rspValidIn) begin
            for (int b = 0; b < BEATS; b++)
              if (cnt_q == 2'(b))
                line_q[b*MEM_WORD_WIDTH +: MEM_WORD_WIDTH] <= mem_rspDataIn;
            // Counter parks on the last beat; RESP takes over from there.
            if (!last_beat) cnt_q <= cnt_q + 2'd1;
          end
        end
        RESP: if (pend_vld_q) tag_q <= pend_tag_q;
        default: ;
      endcase
    end
  end

  // One-deep pending buffer
  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      pend_vld_q <= 1'b0;
      pend_tag_q <= '0;
    end else if (push) begin
      pend_vld_q <= 1'b1;
      pend_tag_q <= cache_reqTagIn;
    end else if (pop) begin
      pend_vld_q <= 1'b0;
    end
  end
endmodule
